// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage: program counter, handshaked instruction fetch,
// IF/ID pipeline register with a one-word hold buffer for hazard stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic [31:0] branch_pc4,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] pc4_reg, pc4_next;
  logic        valid_reg, valid_next;
  logic [31:0] hold_instr_reg, hold_instr_next;
  logic [31:0] hold_pc4_reg, hold_pc4_next;

  logic        redirect;
  logic        accept;
  logic [31:0] pc_plus4;
  logic [31:0] target;

  assign redirect = branch_taken | jump;
  assign accept   = (state_reg == FETCH) && imem_ready;
  assign pc_plus4 = pc_reg + 32'd4;
  // Branch wins over jump when both are asserted.
  assign target   = branch_taken ? (branch_pc4 + (branch_offset << 2))
                                 : {branch_pc4[31:28], jump_index, 2'b00};

  // Gate with rst_n so the request drops immediately on reset assertion.
  assign imem_req    = rst_n && (state_reg == FETCH);
  assign imem_addr   = pc_reg;
  assign if_id_instr = instr_reg;
  assign if_id_pc4   = pc4_reg;
  assign if_id_valid = valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= FETCH;
      pc_reg         <= RESET_PC;
      instr_reg      <= 32'd0;
      pc4_reg        <= 32'd0;
      valid_reg      <= 1'b0;
      hold_instr_reg <= 32'd0;
      hold_pc4_reg   <= 32'd0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      instr_reg      <= instr_next;
      pc4_reg        <= pc4_next;
      valid_reg      <= valid_next;
      hold_instr_reg <= hold_instr_next;
      hold_pc4_reg   <= hold_pc4_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    instr_next      = instr_reg;
    pc4_next        = pc4_reg;
    valid_next      = valid_reg;
    hold_instr_next = hold_instr_reg;
    hold_pc4_next   = hold_pc4_reg;

    if (redirect) begin
      // Flush beats stall; any accepted or buffered word is dropped.
      state_next      = FETCH;
      pc_next         = target;
      valid_next      = 1'b0;
      hold_instr_next = 32'd0;
      hold_pc4_next   = 32'd0;
    end else begin
      unique case (state_reg)
        FETCH: begin
          if (accept) begin
            pc_next = pc_plus4;
            if (stall) begin
              hold_instr_next = imem_rdata;
              hold_pc4_next   = pc_plus4;
              state_next      = HOLD;
            end else begin
              instr_next = imem_rdata;
              pc4_next   = pc_plus4;
              valid_next = 1'b1;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_next = hold_instr_reg;
            pc4_next   = hold_pc4_reg;
            valid_next = 1'b1;
            state_next = FETCH;
          end
        end
        default: state_next = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: a queue-based instruction-level
// model predicts per-cycle outputs; a negedge monitor pops and compares them.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic [31:0] branch_pc4;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .branch_pc4(branch_pc4),
    .jump(jump), .jump_index(jump_index),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
  );

  // Memory contents are a fixed scramble of the address; garbage when not ready.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] addr;
    logic        req;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Model: next fetch address, IF/ID contents, and a queue of fetched-but-stalled words.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic [63:0] m_buf[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("imem_addr",   imem_addr,          mon_e.addr);
      chk("imem_req",    {31'd0, imem_req},  {31'd0, mon_e.req});
      chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, mon_e.valid});
      if (mon_e.valid) begin
        chk("if_id_instr", if_id_instr, mon_e.instr);
        chk("if_id_pc4",   if_id_pc4,   mon_e.pc4);
      end
    end
  end

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_instr = 32'd0;
    m_pc4   = 32'd0;
    m_valid = 1'b0;
    m_buf.delete();
  endtask

  task automatic idle_inputs();
    stall = 1'b0; imem_ready = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_offset = 32'd0; branch_pc4 = 32'd0; jump_index = 26'd0;
  endtask

  task automatic cycle(input logic st, input logic rdy, input logic br, input logic jmp,
                       input logic [31:0] off, input logic [31:0] bpc4, input logic [25:0] idx);
    exp_t        e;
    logic [31:0] w;
    @(posedge clk); #1;
    stall = st; imem_ready = rdy; branch_taken = br; jump = jmp;
    branch_offset = off; branch_pc4 = bpc4; jump_index = idx;
    e.addr = m_pc; e.req = (m_buf.size() == 0);
    e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
    exp_q.push_back(e);
    if (br || jmp) begin
      m_pc    = br ? (bpc4 + off * 32'd4) : {bpc4[31:28], idx, 2'b00};
      m_valid = 1'b0;
      m_buf.delete();
    end else if (m_buf.size() == 0) begin
      if (rdy) begin
        w = mem_word(m_pc);
        if (st) m_buf.push_back({w, m_pc + 32'd4});
        else begin
          m_instr = w; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
        end
        m_pc = m_pc + 32'd4;
      end
    end else if (!st) begin
      {m_instr, m_pc4} = m_buf.pop_front();
      m_valid = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_addr",  imem_addr,            RESET_PC);
    chk("rst_instr", if_id_instr,          32'd0);
    chk("rst_pc4",   if_id_pc4,            32'd0);
    @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;
    #1;
    chk("req_on_release", {31'd0, imem_req}, 32'd1);
    model_reset();
  endtask

  initial begin
    logic        st, rdy, br, jmp;
    logic [15:0] h;
    int          r;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Zero-wait fetches: pc4 4, 8 then ready low three cycles at pc=8.
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    repeat (3) cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    // Stall during accept of pc=16, held two cycles, then release and refetch.
    cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    // Negative branch, branch with stall, branch with jump.
    cycle(0, 1, 1, 0, 32'hFFFF_FFFE, 32'h0000_0100, 26'd0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 32'hFFFF_FFFE, 32'h0000_0100, 26'd0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 1, 32'hFFFF_FFFE, 32'h0000_0100, 26'h3FF_FFFF);
    cycle(0, 1, 0, 0, 0, 0, 0);
    // Jump to region A000_0000.
    cycle(0, 1, 0, 1, 0, 32'hA000_0004, 26'h000_0010);
    cycle(0, 1, 0, 0, 0, 0, 0);
    // Redirect to the top word and wrap past it.
    cycle(0, 0, 1, 0, 32'hFFFF_FFFF, 32'h0000_0000, 26'd0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    // Enter HOLD then reset asynchronously.
    cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    do_reset();

    for (int i = 0; i < 1500; i++) begin
      st  = ($urandom_range(0, 99) < 30);
      rdy = ($urandom_range(0, 99) < 70);
      r   = $urandom_range(0, 99);
      br  = (r < 6);
      jmp = (r >= 4) && (r < 10);
      h   = 16'($urandom);
      cycle(st, rdy, br, jmp, {{16{h[15]}}, h}, $urandom & 32'hFFFF_FFFC, 26'($urandom));
      if (i == 750) do_reset();
    end

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
